// File: rtl/word_serializer.sv
// Word-to-lane serializer: a one-word holding stage feeds a shifting active stage
// that emits WORD_W-bit words as LANE_W-bit lanes over valid/ready handshakes.
module word_serializer #(
    parameter int WORD_W    = 32,
    parameter int LANE_W    = 8,
    parameter int MSB_FIRST = 0,
    localparam int NLANES   = WORD_W / LANE_W,
    localparam int CNT_W    = $clog2(NLANES) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [WORD_W-1:0] in_data,
    input  logic [CNT_W-1:0]  in_lanes,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [LANE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LANES_MAX = CNT_W'(NLANES);
    localparam logic [CNT_W-1:0] LANE_ONE  = CNT_W'(1);

    // A request of 0 or more than NLANES lanes means a full word.
    function automatic logic [CNT_W-1:0] sat_lanes(input logic [CNT_W-1:0] req);
        if (req == '0 || req > LANES_MAX) return LANES_MAX;
        return req;
    endfunction

    function automatic logic [WORD_W-1:0] shift_lane(input logic [WORD_W-1:0] w);
        if (MSB_FIRST != 0) return w << LANE_W;
        return w >> LANE_W;
    endfunction

    logic [WORD_W-1:0] hold_data_p0, hold_data_n;
    logic [CNT_W-1:0]  hold_lanes_p0, hold_lanes_n;
    logic              vld_p0, vld_p0_n;

    logic [WORD_W-1:0] sh_p1, sh_n;
    logic [CNT_W-1:0]  rem_p1, rem_n;
    logic              vld_p1, vld_p1_n;

    logic in_fire;
    logic out_fire;
    logic act_free;

    assign in_ready = !reset && !vld_p0;
    assign in_fire  = in_valid && in_ready && !flush;
    assign out_fire = vld_p1 && out_ready;
    assign act_free = !vld_p1 || (out_fire && rem_p1 == LANE_ONE);

    always_comb begin
        hold_data_n  = hold_data_p0;
        hold_lanes_n = hold_lanes_p0;
        vld_p0_n     = vld_p0;
        sh_n         = sh_p1;
        rem_n        = rem_p1;
        vld_p1_n     = vld_p1;
        if (flush) begin
            hold_data_n  = '0;
            hold_lanes_n = '0;
            vld_p0_n     = 1'b0;
            sh_n         = '0;
            rem_n        = '0;
            vld_p1_n     = 1'b0;
        end else if (act_free) begin
            // in_fire cannot coincide with a held word: in_ready is low while vld_p0 is set.
            if (vld_p0) begin
                sh_n     = hold_data_p0;
                rem_n    = hold_lanes_p0;
                vld_p1_n = 1'b1;
                vld_p0_n = 1'b0;
            end else if (in_fire) begin
                sh_n     = in_data;
                rem_n    = sat_lanes(in_lanes);
                vld_p1_n = 1'b1;
            end else begin
                vld_p1_n = 1'b0;
            end
        end else begin
            if (out_fire) begin
                sh_n  = shift_lane(sh_p1);
                rem_n = rem_p1 - LANE_ONE;
            end
            if (in_fire) begin
                hold_data_n  = in_data;
                hold_lanes_n = sat_lanes(in_lanes);
                vld_p0_n     = 1'b1;
            end
        end
    end

    // Holding stage (p0)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_data_p0  <= '0;
            hold_lanes_p0 <= '0;
            vld_p0        <= 1'b0;
        end else begin
            hold_data_p0  <= hold_data_n;
            hold_lanes_p0 <= hold_lanes_n;
            vld_p0        <= vld_p0_n;
        end
    end

    // Active stage (p1)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_p1  <= '0;
            rem_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            sh_p1  <= sh_n;
            rem_p1 <= rem_n;
            vld_p1 <= vld_p1_n;
        end
    end

    assign out_valid = vld_p1;
    assign out_last  = vld_p1 && (rem_p1 == LANE_ONE);
    assign busy      = vld_p1 || vld_p0;

    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign out_data = sh_p1[WORD_W-1 -: LANE_W];
        end else begin : g_lsb
            assign out_data = sh_p1[LANE_W-1:0];
        end
    endgenerate

endmodule
